dmem_loader: RTL and testbench

DMEM_LOADER -- requirements
Module: dmem_loader

---
 rtl/dmem_loader_pkg.sv | 17 +
 rtl/dmem_loader_byte_shift.sv | 34 +++
 rtl/dmem_loader.sv | 171 +++++++++++++++++
 tb/tb_dmem_loader.sv | 296 +++++++++++++++++++++++++++++
 4 files changed

// File: rtl/dmem_loader_pkg.sv
// Shared widths, memory depth and FSM state encodings for the dmem loader.
package dmem_loader_pkg;

   localparam int DATA_W_C = 32;
   localparam int ADDR_W_C = 16;
   localparam int DEPTH    = 1 << ADDR_W_C;

   typedef enum logic [2:0] {
      ST_IDLE       = 3'd0,
      ST_LD_COLLECT = 3'd1,
      ST_LD_WRITE   = 3'd2,
      ST_DP_READ    = 3'd3,
      ST_DP_SEND    = 3'd4,
      ST_FINISH     = 3'd5
   } state_t;

endpackage

// File: rtl/dmem_loader_byte_shift.sv
// 32-bit byte shift register: parallel load, shift a byte in at the LSB end,
// or shift the MSB byte out. The same register packs load bytes and unpacks dump words.
module dmem_byte_shift
   import dmem_loader_pkg::*;
(
   input  logic                clk,
   input  logic                rst,
   input  logic                i_load,
   input  logic [DATA_W_C-1:0] i_word,
   input  logic                i_shift_in,
   input  logic [7:0]          i_byte,
   input  logic                i_shift_out,
   output logic [DATA_W_C-1:0] o_word,
   output logic [7:0]          o_msb
);

   logic [DATA_W_C-1:0] r_word;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_word <= '0;
      end else if (i_load) begin
         r_word <= i_word;
      end else if (i_shift_in) begin
         r_word <= {r_word[DATA_W_C-9:0], i_byte};
      end else if (i_shift_out) begin
         r_word <= {r_word[DATA_W_C-9:0], 8'h00};
      end
   end

   assign o_word = r_word;
   assign o_msb  = r_word[DATA_W_C-1 -: 8];

endmodule

// File: rtl/dmem_loader.sv
// Host-driven data memory loader: writes words from an input byte stream into dmem,
// or reads dmem words out to an output byte stream, MSB byte first.
//
// state         | meaning
// ST_IDLE       | waiting for start_load / start_dump
// ST_LD_COLLECT | accepting 4 bytes into the pack register
// ST_LD_WRITE   | one-cycle dmem write of the packed word
// ST_DP_READ    | dmem read latched into the unpack register
// ST_DP_SEND    | presenting 4 bytes on the output stream
// ST_FINISH     | one-cycle done pulse
module dmem_loader
   import dmem_loader_pkg::*;
#(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 16
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              start_load,
   input  logic              start_dump,
   input  logic [ADDR_W-1:0] base,
   input  logic [15:0]       count,
   input  logic [7:0]        in_data,
   input  logic              in_valid,
   output logic              in_ready,
   output logic [7:0]        out_data,
   output logic              out_valid,
   input  logic              out_ready,
   output logic [ADDR_W-1:0] a,
   output logic [DATA_W-1:0] wd,
   output logic              we,
   input  logic [DATA_W-1:0] rd,
   output logic              busy,
   output logic              done
);

   state_t            r_state;
   state_t            w_state_nxt;
   logic [ADDR_W-1:0] r_addr;
   logic [15:0]       r_rem;
   logic [1:0]        r_idx;

   logic w_start;
   logic w_last;
   logic w_byte_adv;
   logic w_word_end;
   logic w_sh_load;
   logic w_sh_in;
   logic w_sh_out;
   logic w_we;
   logic w_in_ready;
   logic w_out_valid;
   logic w_done;

   logic [DATA_W-1:0] w_sh_word;
   logic [7:0]        w_sh_msb;

   assign w_start = (r_state == ST_IDLE) && (start_load || start_dump);
   assign w_last  = (r_rem == 16'd1);

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt = r_state;
      w_we        = 1'b0;
      w_in_ready  = 1'b0;
      w_out_valid = 1'b0;
      w_done      = 1'b0;
      w_sh_load   = 1'b0;
      w_sh_in     = 1'b0;
      w_sh_out    = 1'b0;
      w_byte_adv  = 1'b0;
      w_word_end  = 1'b0;
      case (r_state)
         ST_IDLE: begin
            // load has priority when both commands arrive together
            if (start_load) begin
               w_state_nxt = (count == 16'd0) ? ST_FINISH : ST_LD_COLLECT;
            end else if (start_dump) begin
               w_state_nxt = (count == 16'd0) ? ST_FINISH : ST_DP_READ;
            end
         end
         ST_LD_COLLECT: begin
            w_in_ready = 1'b1;
            if (in_valid) begin
               w_sh_in    = 1'b1;
               w_byte_adv = 1'b1;
               if (r_idx == 2'd3) begin
                  w_state_nxt = ST_LD_WRITE;
               end
            end
         end
         ST_LD_WRITE: begin
            w_we        = 1'b1;
            w_word_end  = 1'b1;
            w_state_nxt = w_last ? ST_FINISH : ST_LD_COLLECT;
         end
         ST_DP_READ: begin
            w_sh_load   = 1'b1;
            w_state_nxt = ST_DP_SEND;
         end
         ST_DP_SEND: begin
            w_out_valid = 1'b1;
            if (out_ready) begin
               w_sh_out   = 1'b1;
               w_byte_adv = 1'b1;
               if (r_idx == 2'd3) begin
                  w_word_end  = 1'b1;
                  w_state_nxt = w_last ? ST_FINISH : ST_DP_READ;
               end
            end
         end
         ST_FINISH: begin
            w_done      = 1'b1;
            w_state_nxt = ST_IDLE;
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // byte index wraps 3 -> 0 naturally at each word boundary
   always_ff @(posedge clk) begin
      if (rst) begin
         r_addr <= '0;
         r_rem  <= '0;
         r_idx  <= '0;
      end else if (w_start) begin
         r_addr <= base;
         r_rem  <= count;
         r_idx  <= '0;
      end else begin
         if (w_byte_adv) begin
            r_idx <= r_idx + 2'd1;
         end
         if (w_word_end) begin
            r_addr <= r_addr + 1'b1;
            r_rem  <= r_rem - 16'd1;
         end
      end
   end

   dmem_byte_shift u_shift (
      .clk         (clk),
      .rst         (rst),
      .i_load      (w_sh_load),
      .i_word      (rd),
      .i_shift_in  (w_sh_in),
      .i_byte      (in_data),
      .i_shift_out (w_sh_out),
      .o_word      (w_sh_word),
      .o_msb       (w_sh_msb)
   );

   assign a         = r_addr;
   assign wd        = w_sh_word;
   assign we        = w_we;
   assign in_ready  = w_in_ready;
   assign out_valid = w_out_valid;
   assign out_data  = w_sh_msb;
   assign done      = w_done;
   assign busy      = (r_state != ST_IDLE);

endmodule

// File: tb/tb_dmem_loader.sv
// Directed bench for dmem_loader with a behavioural dmem and scoreboard queues
// for expected dmem writes and expected dump bytes.
module tb_dmem_loader;

   logic        clk = 1'b0;
   logic        rst;
   logic        start_load;
   logic        start_dump;
   logic [15:0] base;
   logic [15:0] count;
   logic [7:0]  in_data;
   logic        in_valid;
   logic        in_ready;
   logic [7:0]  out_data;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] a;
   logic [31:0] wd;
   logic        we;
   logic [31:0] rd;
   logic        busy;
   logic        done;

   logic [31:0] mem [0:65535];

   int checks   = 0;
   int failures = 0;

   logic [47:0] exp_wr[$];
   logic [7:0]  exp_byte[$];

   int   done_cnt = 0;
   int   we_cnt   = 0;
   int   inr_cnt  = 0;
   int   ov_cnt   = 0;
   int   stall_cnt = 0;
   logic stalled  = 1'b0;
   logic [7:0] held = 8'h00;

   always #5 clk = ~clk;

   dmem_loader dut (
      .clk        (clk),
      .rst        (rst),
      .start_load (start_load),
      .start_dump (start_dump),
      .base       (base),
      .count      (count),
      .in_data    (in_data),
      .in_valid   (in_valid),
      .in_ready   (in_ready),
      .out_data   (out_data),
      .out_valid  (out_valid),
      .out_ready  (out_ready),
      .a          (a),
      .wd         (wd),
      .we         (we),
      .rd         (rd),
      .busy       (busy),
      .done       (done)
   );

   assign rd = mem[a];

   always @(posedge clk) begin
      if (we) mem[a] <= wd;
   end

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   always @(negedge clk) begin
      if (done) done_cnt++;
      if (in_ready) inr_cnt++;
      if (we) begin
         we_cnt++;
         chk("wr_expected", 32'(exp_wr.size() != 0), 32'd1);
         if (exp_wr.size() != 0) begin
            logic [47:0] e;
            e = exp_wr.pop_front();
            chk("wr_addr", 32'(a), 32'(e[47:32]));
            chk("wr_data", wd, e[31:0]);
         end
      end
      if (out_valid) begin
         ov_cnt++;
         if (stalled) chk("stall_hold", 32'(out_data), 32'(held));
         if (out_ready) begin
            chk("byte_expected", 32'(exp_byte.size() != 0), 32'd1);
            if (exp_byte.size() != 0) chk("out_byte", 32'(out_data), 32'(exp_byte.pop_front()));
         end else begin
            stall_cnt++;
         end
         stalled = !out_ready;
         held    = out_data;
      end else begin
         stalled = 1'b0;
      end
   end

   task automatic tick;
      @(posedge clk);
      #1;
   endtask

   task automatic cmd(input logic ld, input logic dp, input logic [15:0] b, input logic [15:0] c);
      start_load = ld;
      start_dump = dp;
      base       = b;
      count      = c;
      tick();
      start_load = 1'b0;
      start_dump = 1'b0;
   endtask

   task automatic send_byte(input logic [7:0] b);
      logic hs;
      int   g;
      hs = 1'b0;
      g  = 0;
      in_data  = b;
      in_valid = 1'b1;
      while (!hs && g < 50) begin
         @(negedge clk);
         hs = in_ready;
         tick();
         g++;
      end
      in_valid = 1'b0;
      chk("in_handshake", 32'(hs), 32'd1);
   endtask

   task automatic send_word(input logic [31:0] w);
      for (int i = 3; i >= 0; i--) send_byte(w[i*8 +: 8]);
   endtask

   task automatic wait_done(input int target);
      int g;
      g = 0;
      while (done_cnt < target && g < 2000) begin
         tick();
         g++;
      end
      chk("done_count", 32'(done_cnt), 32'(target));
      tick();
      chk("idle_after_done", 32'(busy), 32'd0);
      chk("single_done", 32'(done_cnt), 32'(target));
   endtask

   task automatic push_dump_bytes;
      logic [31:0] w [3];
      w[0] = 32'h04050406;
      w[1] = 32'h04070507;
      w[2] = 32'h06070000;
      for (int k = 0; k < 3; k++)
         for (int i = 3; i >= 0; i--) exp_byte.push_back(w[k][i*8 +: 8]);
   endtask

   initial begin
      int nd;
      int we0;
      int inr0;
      int ov0;
      int g;

      rst        = 1'b1;
      start_load = 1'b0;
      start_dump = 1'b0;
      base       = '0;
      count      = '0;
      in_data    = '0;
      in_valid   = 1'b0;
      out_ready  = 1'b1;
      for (int i = 0; i < 65536; i++) mem[i] <= 32'h0;
      tick();
      tick();
      rst = 1'b0;
      tick();

      chk("rst_busy", 32'(busy), 32'd0);
      chk("rst_done", 32'(done), 32'd0);
      chk("rst_we", 32'(we), 32'd0);
      chk("rst_in_ready", 32'(in_ready), 32'd0);
      chk("rst_out_valid", 32'(out_valid), 32'd0);
      chk("rst_a", 32'(a), 32'd0);
      chk("rst_wd", wd, 32'd0);
      chk("rst_out_data", 32'(out_data), 32'd0);

      // two-word load
      nd = 0;
      exp_wr.push_back({16'h0000, 32'h080e0001});
      exp_wr.push_back({16'h0001, 32'h00020004});
      cmd(1'b1, 1'b0, 16'h0000, 16'd2);
      chk("load_busy", 32'(busy), 32'd1);
      send_word(32'h080e0001);
      send_word(32'h00020004);
      nd++;
      wait_done(nd);
      chk("load_mem0", mem[0], 32'h080e0001);
      chk("load_mem1", mem[1], 32'h00020004);
      chk("load_wr_drained", 32'(exp_wr.size()), 32'd0);

      // dump three words with out_ready held high
      mem[5] <= 32'h04050406;
      mem[6] <= 32'h04070507;
      mem[7] <= 32'h06070000;
      tick();
      we0 = we_cnt;
      push_dump_bytes();
      cmd(1'b0, 1'b1, 16'h0005, 16'd3);
      nd++;
      wait_done(nd);
      chk("dump_bytes_drained", 32'(exp_byte.size()), 32'd0);
      chk("dump_no_we", 32'(we_cnt), 32'(we0));

      // same dump with random backpressure
      we0 = we_cnt;
      push_dump_bytes();
      cmd(1'b0, 1'b1, 16'h0005, 16'd3);
      g = 0;
      while (done_cnt < nd + 1 && g < 2000) begin
         out_ready = 1'($urandom_range(0, 1));
         tick();
         g++;
      end
      out_ready = 1'b1;
      nd++;
      wait_done(nd);
      chk("rand_bytes_drained", 32'(exp_byte.size()), 32'd0);
      chk("rand_no_we", 32'(we_cnt), 32'(we0));
      chk("rand_stalls_seen", 32'(stall_cnt > 0), 32'd1);

      // zero-count load
      we0  = we_cnt;
      inr0 = inr_cnt;
      cmd(1'b1, 1'b0, 16'h0040, 16'd0);
      chk("zero_done_hi", 32'(done), 32'd1);
      chk("zero_busy_hi", 32'(busy), 32'd1);
      tick();
      chk("zero_done_lo", 32'(done), 32'd0);
      chk("zero_busy_lo", 32'(busy), 32'd0);
      nd++;
      chk("zero_done_count", 32'(done_cnt), 32'(nd));
      chk("zero_no_we", 32'(we_cnt), 32'(we0));
      chk("zero_no_in_ready", 32'(inr_cnt), 32'(inr0));

      // reset after two of four load bytes
      mem[16'h20] <= 32'hdeadbeef;
      tick();
      we0 = we_cnt;
      cmd(1'b1, 1'b0, 16'h0020, 16'd1);
      send_byte(8'h99);
      send_byte(8'h88);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      chk("midrst_busy", 32'(busy), 32'd0);
      chk("midrst_in_ready", 32'(in_ready), 32'd0);
      tick();
      chk("midrst_no_we", 32'(we_cnt), 32'(we0));
      chk("midrst_mem_kept", mem[16'h20], 32'hdeadbeef);
      exp_wr.push_back({16'h0020, 32'h11223344});
      cmd(1'b1, 1'b0, 16'h0020, 16'd1);
      send_word(32'h11223344);
      nd++;
      wait_done(nd);
      chk("reload_mem", mem[16'h20], 32'h11223344);
      chk("reload_one_we", 32'(we_cnt), 32'(we0 + 1));

      // simultaneous commands, then dump request while busy
      ov0 = ov_cnt;
      exp_wr.push_back({16'h0030, 32'ha1b2c3d4});
      cmd(1'b1, 1'b1, 16'h0030, 16'd1);
      start_dump = 1'b1;
      base       = 16'h0005;
      count      = 16'd3;
      send_word(32'ha1b2c3d4);
      start_dump = 1'b0;
      nd++;
      wait_done(nd);
      chk("both_mem", mem[16'h30], 32'ha1b2c3d4);
      chk("both_no_dump", 32'(ov_cnt), 32'(ov0));

      chk("final_wr_drained", 32'(exp_wr.size()), 32'd0);
      chk("final_bytes_drained", 32'(exp_byte.size()), 32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
